// File: rtl/scr1_imem_ahb_pq_if.sv
// Bus bundle for the IMEM fetch queue: core-side request/response signals plus the AHB-Lite
// master signals. The "master" modport is the bridge's view; "slave" is the core+fabric view.
interface scr1_imem_ahb_pq_if #(
   parameter int REQ_DEPTH = 2
) ();
   localparam int CNT_W = $clog2(REQ_DEPTH + 1);

   logic              imem_req;
   logic [31:0]       imem_addr;
   logic              imem_req_ack;
   logic              imem_flush;
   logic [31:0]       imem_rdata;
   logic [1:0]        imem_resp;
   logic [CNT_W-1:0]  req_level;

   logic [3:0]        hprot;
   logic [2:0]        hburst;
   logic [2:0]        hsize;
   logic [1:0]        htrans;
   logic              hmastlock;
   logic [31:0]       haddr;
   logic              hready;
   logic [31:0]       hrdata;
   logic              hresp;

   modport master (
      input  imem_req, imem_addr, imem_flush, hready, hrdata, hresp,
      output imem_req_ack, imem_rdata, imem_resp, req_level,
             hprot, hburst, hsize, htrans, hmastlock, haddr
   );

   modport slave (
      output imem_req, imem_addr, imem_flush, hready, hrdata, hresp,
      input  imem_req_ack, imem_rdata, imem_resp, req_level,
             hprot, hburst, hsize, htrans, hmastlock, haddr
   );
endinterface

// File: rtl/scr1_imem_ahb_pq.sv
// IMEM fetch request queue driving pipelined single-word AHB-Lite NONSEQ reads, with optional
// request bypass, registered or pass-through response, two-cycle ERROR handling and flush.
module scr1_imem_ahb_pq_chk #(
   parameter int REQ_DEPTH = 2,
   parameter int CNT_W     = 2
) (
   input logic             clk,
   input logic             rst_n,
   input logic [CNT_W-1:0] cnt,
   input logic             push,
   input logic             pop,
   input logic             flush
);
   a_cnt_max: assert property (@(posedge clk) disable iff (!rst_n)
      cnt <= CNT_W'(REQ_DEPTH));
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && !pop && !flush && (cnt == CNT_W'(REQ_DEPTH))));
   a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(pop && !push && !flush && (cnt == {CNT_W{1'b0}})));
endmodule

module scr1_imem_ahb_pq #(
   parameter int REQ_DEPTH  = 2,
   parameter bit REQ_BYPASS = 1'b0,
   parameter bit RESP_REG   = 1'b1,
   parameter int CNT_W      = $clog2(REQ_DEPTH + 1)
) (
   input logic                clk,
   input logic                rst_n,
   scr1_imem_ahb_pq_if.master bus
);
   localparam int         PTR_W         = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
   localparam logic [1:0] RESP_NOTRDY   = 2'b00;
   localparam logic [1:0] RESP_RDY_OK   = 2'b01;
   localparam logic [1:0] RESP_RDY_ER   = 2'b10;
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HSIZE_32      = 3'b010;
   localparam logic       HRESP_ERROR   = 1'b1;

   typedef enum logic {ST_ADDR = 1'b0, ST_DATA = 1'b1} fsm_e;

   fsm_e             fsm_r;
   logic             drop_r;
   logic [CNT_W-1:0] cnt_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W-1:0] wr_ptr_r;
   logic [31:0]      fifo_r [REQ_DEPTH];

   logic             full_s;
   logic             empty_s;
   logic             req_ack_s;
   logic             bypass_s;
   logic             issue_s;
   logic             accept_s;
   logic             push_s;
   logic             pop_s;
   logic             cmpl_s;
   logic [1:0]       resp_next_s;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(REQ_DEPTH - 1)) begin
         ptr_inc = {PTR_W{1'b0}};
      end else begin
         ptr_inc = p + PTR_W'(1);
      end
   endfunction

   // Queue status, bypass qualification, address-phase issue and completion decode.
   always_comb begin
      full_s    = (cnt_r == CNT_W'(REQ_DEPTH));
      empty_s   = (cnt_r == {CNT_W{1'b0}});
      req_ack_s = !full_s && !bus.imem_flush;
      if (REQ_BYPASS && (fsm_r == ST_ADDR) && empty_s && bus.imem_req && !bus.imem_flush) begin
         bypass_s = 1'b1;
      end else begin
         bypass_s = 1'b0;
      end
      case (fsm_r)
         ST_ADDR: issue_s = (!empty_s || bypass_s) && !bus.imem_flush;
         // Pipeline the next address only while the current data phase ends with OKAY.
         ST_DATA: issue_s = bus.hready && (bus.hresp != HRESP_ERROR) && !empty_s && !bus.imem_flush;
         default: issue_s = 1'b0;
      endcase
      accept_s = issue_s && bus.hready;
      pop_s    = accept_s && !empty_s;
      push_s   = bus.imem_req && req_ack_s && !(bypass_s && bus.hready);
      cmpl_s   = (fsm_r == ST_DATA) && bus.hready && !drop_r && !bus.imem_flush;
      if (cmpl_s) begin
         resp_next_s = (bus.hresp == HRESP_ERROR) ? RESP_RDY_ER : RESP_RDY_OK;
      end else begin
         resp_next_s = RESP_NOTRDY;
      end
   end

   // Transfer sequencer: address/data phase tracking and dropping of a flushed data phase.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_r  <= ST_ADDR;
         drop_r <= 1'b0;
      end else begin
         case (fsm_r)
            ST_ADDR: begin
               if (accept_s) fsm_r <= ST_DATA;
               else          fsm_r <= ST_ADDR;
            end
            ST_DATA: begin
               if (bus.hready) fsm_r <= accept_s ? ST_DATA : ST_ADDR;
               else            fsm_r <= ST_DATA;
            end
            default: fsm_r <= ST_ADDR;
         endcase
         if ((fsm_r == ST_DATA) && bus.hready) begin
            drop_r <= 1'b0;
         end else if ((fsm_r == ST_DATA) && bus.imem_flush) begin
            drop_r <= 1'b1;
         end else begin
            drop_r <= drop_r;
         end
      end
   end

   // Request FIFO storage, pointers and occupancy; flush empties it in one edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r    <= {CNT_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         wr_ptr_r <= {PTR_W{1'b0}};
         for (int i = 0; i < REQ_DEPTH; i++) begin
            fifo_r[i] <= 32'h0000_0000;
         end
      end else if (bus.imem_flush) begin
         cnt_r    <= {CNT_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         wr_ptr_r <= {PTR_W{1'b0}};
      end else begin
         if (push_s) begin
            fifo_r[wr_ptr_r] <= bus.imem_addr;
            wr_ptr_r         <= ptr_inc(wr_ptr_r);
         end
         if (pop_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
         case ({push_s, pop_s})
            2'b10:   cnt_r <= cnt_r + CNT_W'(1);
            2'b01:   cnt_r <= cnt_r - CNT_W'(1);
            default: cnt_r <= cnt_r;
         endcase
      end
   end

   generate
      if (RESP_REG) begin : g_resp_reg
         logic [1:0]  resp_r;
         logic [31:0] rdata_r;

         // Response register: valid for exactly one cycle after a reported completion.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               resp_r  <= RESP_NOTRDY;
               rdata_r <= 32'h0000_0000;
            end else begin
               resp_r <= resp_next_s;
               if (cmpl_s) rdata_r <= bus.hrdata;
               else        rdata_r <= rdata_r;
            end
         end

         assign bus.imem_resp  = resp_r;
         assign bus.imem_rdata = rdata_r;
      end else begin : g_resp_comb
         assign bus.imem_resp  = resp_next_s;
         assign bus.imem_rdata = bus.hrdata;
      end
   endgenerate

   assign bus.imem_req_ack = req_ack_s;
   assign bus.req_level    = cnt_r;
   assign bus.hprot        = 4'b0000;
   assign bus.hburst       = HBURST_SINGLE;
   assign bus.hsize        = HSIZE_32;
   assign bus.hmastlock    = 1'b0;
   assign bus.htrans       = issue_s ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign bus.haddr        = bypass_s ? bus.imem_addr : fifo_r[rd_ptr_r];

   scr1_imem_ahb_pq_chk #(
      .REQ_DEPTH (REQ_DEPTH),
      .CNT_W     (CNT_W)
   ) u_chk (
      .clk   (clk),
      .rst_n (rst_n),
      .cnt   (cnt_r),
      .push  (push_s),
      .pop   (pop_s),
      .flush (bus.imem_flush)
   );
endmodule

// File: tb/tb_scr1_imem_ahb_pq.sv
// Directed bench: dut0 is the default queue (registered response), dut1 uses bypass with a
// pass-through response. A small AHB slave per DUT returns mem_f(addr) in each data phase.
module tb_scr1_imem_ahb_pq;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   scr1_imem_ahb_pq_if #(.REQ_DEPTH(2)) if0 ();
   scr1_imem_ahb_pq_if #(.REQ_DEPTH(2)) if1 ();

   scr1_imem_ahb_pq #(.REQ_DEPTH(2), .REQ_BYPASS(1'b0), .RESP_REG(1'b1)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .bus(if0.master));
   scr1_imem_ahb_pq #(.REQ_DEPTH(2), .REQ_BYPASS(1'b1), .RESP_REG(1'b0)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .bus(if1.master));

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_f(input logic [31:0] a);
      mem_f = {a[15:0], ~a[15:0]};
   endfunction

   logic        dp0_v, dp1_v;
   logic [31:0] dp0_a, dp1_a;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dp0_v <= 1'b0; dp0_a <= 32'h0; dp1_v <= 1'b0; dp1_a <= 32'h0;
      end else begin
         if (if0.hready) begin dp0_v <= (if0.htrans == 2'b10); dp0_a <= if0.haddr; end
         if (if1.hready) begin dp1_v <= (if1.htrans == 2'b10); dp1_a <= if1.haddr; end
      end
   end
   assign if0.hrdata = dp0_v ? mem_f(dp0_a) : 32'h0;
   assign if1.hrdata = dp1_v ? mem_f(dp1_a) : 32'h0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      if0.imem_req = 1'b0; if0.imem_addr = 32'h0; if0.imem_flush = 1'b0; if0.hready = 1'b1; if0.hresp = 1'b0;
      if1.imem_req = 1'b0; if1.imem_addr = 32'h0; if1.imem_flush = 1'b0; if1.hready = 1'b1; if1.hresp = 1'b0;
      #3;
      chk("rst0_resp",  32'(if0.imem_resp),    32'd0);
      chk("rst0_trans", 32'(if0.htrans),       32'd0);
      chk("rst0_ack",   32'(if0.imem_req_ack), 32'd1);
      chk("rst0_level", 32'(if0.req_level),    32'd0);
      chk("rst1_resp",  32'(if1.imem_resp),    32'd0);
      chk("rst1_trans", 32'(if1.htrans),       32'd0);
      chk("const_hsize",  32'(if0.hsize),  32'd2);
      chk("const_hburst", 32'(if0.hburst), 32'd0);
      #5 rst_n = 1'b1;
      nxt();

      // Single fetch of 0x100
      if0.imem_req = 1'b1; if0.imem_addr = 32'h100; #1;
      chk("t1_ack", 32'(if0.imem_req_ack), 32'd1);
      chk("t1_idle0", 32'(if0.htrans), 32'd0); nxt();
      if0.imem_req = 1'b0; #1;
      chk("t1_nonseq", 32'(if0.htrans), 32'd2);
      chk("t1_haddr", if0.haddr, 32'h100);
      chk("t1_level", 32'(if0.req_level), 32'd1); nxt();
      #1;
      chk("t1_idle2", 32'(if0.htrans), 32'd0);
      chk("t1_notrdy2", 32'(if0.imem_resp), 32'd0);
      chk("t1_level2", 32'(if0.req_level), 32'd0); nxt();
      #1;
      chk("t1_resp", 32'(if0.imem_resp), 32'd1);
      chk("t1_rdata", if0.imem_rdata, 32'h0100_FEFF); nxt();
      #1;
      chk("t1_resp_gone", 32'(if0.imem_resp), 32'd0); nxt();

      // Back-to-back fetches 0x0..0xC
      if0.imem_req = 1'b1; if0.imem_addr = 32'h0; #1;
      chk("t2_c0_idle", 32'(if0.htrans), 32'd0); nxt();
      if0.imem_addr = 32'h4; #1;
      chk("t2_c1_haddr", if0.haddr, 32'h0);
      chk("t2_c1_trans", 32'(if0.htrans), 32'd2); nxt();
      if0.imem_addr = 32'h8; #1;
      chk("t2_c2_haddr", if0.haddr, 32'h4);
      chk("t2_c2_trans", 32'(if0.htrans), 32'd2); nxt();
      if0.imem_addr = 32'hC; #1;
      chk("t2_c3_haddr", if0.haddr, 32'h8);
      chk("t2_c3_resp", 32'(if0.imem_resp), 32'd1);
      chk("t2_c3_rdata", if0.imem_rdata, 32'h0000_FFFF); nxt();
      if0.imem_req = 1'b0; #1;
      chk("t2_c4_haddr", if0.haddr, 32'hC);
      chk("t2_c4_trans", 32'(if0.htrans), 32'd2);
      chk("t2_c4_rdata", if0.imem_rdata, 32'h0004_FFFB); nxt();
      #1;
      chk("t2_c5_idle", 32'(if0.htrans), 32'd0);
      chk("t2_c5_rdata", if0.imem_rdata, 32'h0008_FFF7); nxt();
      #1;
      chk("t2_c6_resp", 32'(if0.imem_resp), 32'd1);
      chk("t2_c6_rdata", if0.imem_rdata, 32'h000C_FFF3); nxt();
      #1;
      chk("t2_c7_resp", 32'(if0.imem_resp), 32'd0); nxt();

      // Bypass with combinational response on dut1
      if1.imem_req = 1'b1; if1.imem_addr = 32'h40; #1;
      chk("t3_trans", 32'(if1.htrans), 32'd2);
      chk("t3_haddr", if1.haddr, 32'h40);
      chk("t3_resp0", 32'(if1.imem_resp), 32'd0); nxt();
      if1.imem_req = 1'b0; #1;
      chk("t3_level", 32'(if1.req_level), 32'd0);
      chk("t3_resp", 32'(if1.imem_resp), 32'd1);
      chk("t3_rdata", if1.imem_rdata, 32'h0040_FFBF); nxt();
      #1;
      chk("t3_resp_gone", 32'(if1.imem_resp), 32'd0); nxt();

      // Two-cycle ERROR on 0x200 with 0x204 queued
      if0.imem_req = 1'b1; if0.imem_addr = 32'h200; #1; nxt();
      if0.imem_addr = 32'h204; #1;
      chk("t4_haddr", if0.haddr, 32'h200); nxt();
      if0.imem_req = 1'b0; if0.hready = 1'b0; if0.hresp = 1'b1; #1;
      chk("t4_err1_idle", 32'(if0.htrans), 32'd0);
      chk("t4_level", 32'(if0.req_level), 32'd1); nxt();
      if0.hready = 1'b1; #1;
      chk("t4_err2_idle", 32'(if0.htrans), 32'd0); nxt();
      if0.hresp = 1'b0; #1;
      chk("t4_rdy_er", 32'(if0.imem_resp), 32'd2);
      chk("t4_next_trans", 32'(if0.htrans), 32'd2);
      chk("t4_next_haddr", if0.haddr, 32'h204); nxt();
      #1;
      chk("t4_notrdy", 32'(if0.imem_resp), 32'd0); nxt();
      #1;
      chk("t4_ok", 32'(if0.imem_resp), 32'd1);
      chk("t4_rdata", if0.imem_rdata, 32'h0204_FDFB); nxt();

      // Flush during a 3-wait data phase of 0x300 with 0x304/0x308 queued
      if0.imem_req = 1'b1; if0.imem_addr = 32'h300; #1; nxt();
      if0.imem_addr = 32'h304; #1;
      chk("t5_haddr", if0.haddr, 32'h300); nxt();
      if0.imem_addr = 32'h308; if0.hready = 1'b0; #1;
      chk("t5_ack_w1", 32'(if0.imem_req_ack), 32'd1); nxt();
      if0.imem_req = 1'b0; #1;
      chk("t5_full_level", 32'(if0.req_level), 32'd2);
      chk("t5_full_ack", 32'(if0.imem_req_ack), 32'd0); nxt();
      if0.imem_flush = 1'b1; #1;
      chk("t5_flush_ack", 32'(if0.imem_req_ack), 32'd0);
      chk("t5_flush_idle", 32'(if0.htrans), 32'd0); nxt();
      if0.imem_flush = 1'b0; if0.hready = 1'b1; #1;
      chk("t5_level0", 32'(if0.req_level), 32'd0);
      chk("t5_done_idle", 32'(if0.htrans), 32'd0);
      chk("t5_resp_a", 32'(if0.imem_resp), 32'd0); nxt();
      if0.imem_req = 1'b1; if0.imem_addr = 32'h500; #1;
      chk("t5_dropped", 32'(if0.imem_resp), 32'd0);
      chk("t5_no_issue", 32'(if0.htrans), 32'd0); nxt();
      if0.imem_req = 1'b0; #1;
      chk("t5_new_haddr", if0.haddr, 32'h500);
      chk("t5_new_trans", 32'(if0.htrans), 32'd2); nxt();
      #1; nxt();
      #1;
      chk("t5_new_resp", 32'(if0.imem_resp), 32'd1);
      chk("t5_new_rdata", if0.imem_rdata, 32'h0500_FAFF); nxt();

      // Asynchronous reset in the middle of a data phase
      if0.imem_req = 1'b1; if0.imem_addr = 32'h0; #1; nxt();
      if0.imem_addr = 32'h4; #1;
      chk("t6_haddr", if0.haddr, 32'h0); nxt();
      if0.imem_req = 1'b0; if0.hready = 1'b0; #1;
      chk("t6_level_pre", 32'(if0.req_level), 32'd1);
      #3 rst_n = 1'b0; #1;
      chk("t6_rst_level", 32'(if0.req_level), 32'd0);
      chk("t6_rst_trans", 32'(if0.htrans), 32'd0);
      chk("t6_rst_ack", 32'(if0.imem_req_ack), 32'd1);
      chk("t6_rst_resp", 32'(if0.imem_resp), 32'd0);
      #2 rst_n = 1'b1; if0.hready = 1'b1;
      nxt();
      if0.imem_req = 1'b1; if0.imem_addr = 32'h0; #1;
      chk("t6_post_idle", 32'(if0.htrans), 32'd0); nxt();
      if0.imem_req = 1'b0; #1;
      chk("t6_post_trans", 32'(if0.htrans), 32'd2);
      chk("t6_post_haddr", if0.haddr, 32'h0); nxt();
      #1;
      chk("t6_post_notrdy", 32'(if0.imem_resp), 32'd0); nxt();
      #1;
      chk("t6_post_resp", 32'(if0.imem_resp), 32'd1);
      chk("t6_post_rdata", if0.imem_rdata, 32'h0000_FFFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/scr1_imem_ahb_pq.md
Name: scr1_imem_ahb_pq

Overview:
Parametrised instruction-fetch bridge from the core IMEM request/response interface to an AHB-Lite master. It queues fetch requests in a REQ_DEPTH-entry request FIFO and issues pipelined single 32-bit NONSEQ reads. New capabilities: optional zero-latency request bypass, selectable registered or combinational response path, two-cycle AHB ERROR handling, and an imem_flush input that drops queued requests and suppresses in-flight responses (branch redirect). Sits between the core fetch unit and the IMEM AHB fabric in the top level.

Parameters:
REQ_DEPTH, 2, request FIFO entries; legal range 1..8.
REQ_BYPASS, 0, 1: with an empty FIFO in the ADDR state, imem_addr drives haddr in the same cycle as imem_req.
RESP_REG, 1, 1: response registered (+1 cycle); 0: response is a combinational pass-through of hrdata/hresp.
CNT_W, $clog2(REQ_DEPTH+1), width of the FIFO level counter (derived; do not override).

Ports:
clk  in  1  clock; all state on posedge.
rst_n  in  1  asynchronous active-low reset.
imem_req  in  1  fetch request.
imem_addr  in  32  fetch address; word aligned.
imem_req_ack  out  1  request accepted; = ~full & ~imem_flush.
imem_flush  in  1  drops queued requests and suppresses in-flight responses.
imem_rdata  out  32  fetch data.
imem_resp  out  2  type_scr1_mem_resp_e: NOTRDY, RDY_OK, RDY_ER.
req_level  out  CNT_W  current FIFO occupancy.
hprot  out  4  constant 0.
hburst  out  3  constant SINGLE.
hsize  out  3  constant 32B.
htrans  out  2  IDLE/NONSEQ only.
hmastlock  out  1  constant 0.
haddr  out  32  head-of-FIFO address (or imem_addr on bypass).
hready  in  1  AHB ready.
hrdata  in  32  AHB read data.
hresp  in  1  OKAY/ERROR.

Behaviour:
- Reset: FIFO count 0, fsm=ADDR, drop=0, response-valid register 0 -> imem_resp=NOTRDY, htrans=IDLE, imem_req_ack=1, req_level=0.
- Push: imem_req & imem_req_ack; the entry goes to the tail. No push is allowed when full, even with a simultaneous pop.
- Pop: an address phase is accepted (htrans==NONSEQ & hready). Simultaneous push and pop leaves the count unchanged.
- Bypass (REQ_BYPASS=1): with the FIFO empty and fsm=ADDR, imem_req presents NONSEQ with haddr=imem_addr. If hready=1, the request is consumed without being written. Otherwise it is written and issued from the FIFO in later cycles.
- FSM, ADDR state:
  - htrans=NONSEQ iff nonempty (or bypass) and ~imem_flush.
  - On hready with a NONSEQ issued -> DATA; otherwise stay in ADDR.
- FSM, DATA state:
  - hready=0 & hresp=OKAY: wait, htrans=IDLE.
  - hresp=ERROR & hready=0 (first ERROR cycle): htrans=IDLE forced.
  - hready=1 & OKAY: the transfer completes. Pipeline the next NONSEQ if nonempty & ~imem_flush (stay in DATA); otherwise go to ADDR.
  - hready=1 & ERROR: the transfer completes with error, htrans=IDLE, -> ADDR. Queued requests remain and issue later in order.
- Completion qualifier: cmpl = (fsm==DATA) & hready & ~drop & ~imem_flush.
  - RESP_REG=1: imem_resp/imem_rdata are registered from cmpl/hresp/hrdata. imem_resp is RDY_* exactly one cycle after completion, NOTRDY otherwise.
  - RESP_REG=0: imem_resp is driven combinationally in the completion cycle.
- Flush:
  - In the flush cycle: imem_req_ack=0 and htrans=IDLE.
  - Count is cleared at the next edge.
  - If fsm==DATA & ~hready, drop is set. drop is cleared when that data phase completes, and that response is NOT reported.
  - A completion coinciding with the flush cycle is also suppressed.
  - A registered response already valid in the flush cycle (earlier completion) is still delivered.
- Asynchronous reset mid-transfer abandons all state. The bench must not count the response.
- req_level mirrors the count. The count never exceeds REQ_DEPTH or wraps below 0; implementations guard with assertions.

Test Plan:
- Single fetch, REQ_DEPTH=2, RESP_REG=1, zero-wait slave: req addr 0x100 at cycle 0 -> NONSEQ haddr 0x100 cycle 1; RDY_OK with rdata=mem[0x100] at cycle 3.
- Back-to-back 4 fetches 0x0..0xC with hready=1: NONSEQ on consecutive cycles with pipelined data; imem_req_ack drops when level=2; 4 RDY_OK in order.
- REQ_BYPASS=1, RESP_REG=0, empty FIFO: req 0x40 -> haddr=0x40, NONSEQ in the same cycle; RDY_OK in the next cycle; req_level stays 0.
- Two-cycle ERROR on 0x200 with 0x204 queued: htrans=IDLE during both ERROR cycles; RDY_ER for 0x200; then 0x204 is issued and returns RDY_OK.
- Flush during a 3-wait-state data phase of 0x300 with 0x304/0x308 queued: no response for 0x300; 0x304/0x308 are never issued; level=0; a new req 0x500 afterwards returns RDY_OK.
- Async rst_n assert mid-DATA: all outputs return to reset values immediately; after release, a fetch of 0x0 completes normally.
